// File: rtl/rl_pkg.sv
// Shared types and constants for the Q-learning update datapath.
// Q values are signed Q8.8; learning rate and discount are unsigned Q8.8.
package rl_pkg;

    localparam int Q_W         = 16;
    localparam int FRAC_W      = 8;
    localparam int NUM_ACTIONS = 4;
    // Wide enough for alpha * td without overflow (17-bit x ~26-bit signed).
    localparam int CALC_W      = 48;

    typedef logic signed [Q_W-1:0] q_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CALC,
        WRITE
    } fsm_t;

    function automatic logic is_one_hot(input logic [NUM_ACTIONS-1:0] a);
        return (a != '0) && ((a & (a - 1'b1)) == '0);
    endfunction

    function automatic logic [1:0] act_idx(input logic [NUM_ACTIONS-1:0] a);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_ACTIONS; i++) begin
            if (a[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/q_max4.sv
// Combinational signed maximum of four Q values.
module q_max4
    import rl_pkg::*;
(
    input  q_t q0,
    input  q_t q1,
    input  q_t q2,
    input  q_t q3,
    output q_t q_max
);

    q_t max01;
    q_t max23;

    // Two-level compare tree over signed Q8.8 values
    always_comb begin
        max01 = (q0 >= q1) ? q0 : q1;
        max23 = (q2 >= q3) ? q2 : q3;
        q_max = (max01 >= max23) ? max01 : max23;
    end

endmodule

// File: rtl/q_updater.sv
// Q-table with a four-state one-step Q-learning update engine and a
// registered row read port.
// Optional build macro Q_UPDATER_SAT_EN: saturate q+delta to 0x8000..0x7FFF
// instead of wrapping to the low 16 bits.
module q_updater
    import rl_pkg::*;
#(
    parameter int NUM_STATES = 16,
    parameter int STATE_W    = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [STATE_W-1:0] state,
    input  logic [STATE_W-1:0] next_state,
    input  logic [3:0]         action,
    input  logic [15:0]        reward,
    input  logic [15:0]        alpha,
    input  logic [15:0]        gamma,
    output logic               upd_done,
    output logic               upd_err,
    input  logic [STATE_W-1:0] rd_state,
    output logic [63:0]        rd_q_values
);

`ifdef Q_UPDATER_SAT_EN
    localparam logic signed [CALC_W-1:0] Q_MAX_X = {{(CALC_W-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
    localparam logic signed [CALC_W-1:0] Q_MIN_X = {{(CALC_W-Q_W+1){1'b1}}, {(Q_W-1){1'b0}}};
`endif

    fsm_t                      st;
    logic [STATE_W-1:0]        s_r;
    logic [STATE_W-1:0]        ns_r;
    logic [NUM_ACTIONS-1:0]    a_r;
    q_t                        r_r;
    logic [Q_W-1:0]            alpha_r;
    logic [Q_W-1:0]            gamma_r;
    q_t                        q_r;
    q_t                        m_r;
    q_t                        m_w;
    q_t                        new_q;
    logic signed [CALC_W-1:0]  delta_r;
    logic signed [CALC_W-1:0]  delta_w;
    logic signed [CALC_W-1:0]  sum_w;
    logic signed [CALC_W-1:0]  gamma_x;
    logic signed [CALC_W-1:0]  alpha_x;
    logic signed [CALC_W-1:0]  m_x;
    logic signed [CALC_W-1:0]  q_x;
    logic signed [CALC_W-1:0]  r_x;
    logic signed [CALC_W-1:0]  gm;
    logic signed [CALC_W-1:0]  td;
    logic signed [CALC_W-1:0]  prod;
    logic [1:0]                a_idx;
    logic                      a_ok;
    logic                      unused_sum_hi;

    q_t tbl [NUM_STATES][NUM_ACTIONS];

    assign a_idx = act_idx(a_r);
    assign a_ok  = is_one_hot(a_r);

    q_max4 u_max (
        .q0    (tbl[ns_r][0]),
        .q1    (tbl[ns_r][1]),
        .q2    (tbl[ns_r][2]),
        .q3    (tbl[ns_r][3]),
        .q_max (m_w)
    );

    // TD error and scaled delta; shifts are arithmetic so truncation floors
    always_comb begin
        gamma_x = {{(CALC_W-Q_W){1'b0}}, gamma_r};
        alpha_x = {{(CALC_W-Q_W){1'b0}}, alpha_r};
        m_x     = {{(CALC_W-Q_W){m_r[Q_W-1]}}, m_r};
        q_x     = {{(CALC_W-Q_W){q_r[Q_W-1]}}, q_r};
        r_x     = {{(CALC_W-Q_W){r_r[Q_W-1]}}, r_r};
        gm      = gamma_x * m_x;
        td      = r_x + (gm >>> FRAC_W) - q_x;
        prod    = alpha_x * td;
        delta_w = prod >>> FRAC_W;
    end

    // Updated entry value: wrap by default, clamp when saturation is built in
    always_comb begin
        sum_w = q_x + delta_r;
        new_q = sum_w[Q_W-1:0];
`ifdef Q_UPDATER_SAT_EN
        if (sum_w > Q_MAX_X) begin
            new_q = {1'b0, {(Q_W-1){1'b1}}};
        end else if (sum_w < Q_MIN_X) begin
            new_q = {1'b1, {(Q_W-1){1'b0}}};
        end
`endif
    end

    assign unused_sum_hi = ^sum_w[CALC_W-1:Q_W];

    // Update sequencer: accept, fetch q and max, compute delta, write back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            upd_ready <= 1'b1;
            upd_done  <= 1'b0;
            upd_err   <= 1'b0;
            s_r       <= '0;
            ns_r      <= '0;
            a_r       <= '0;
            r_r       <= '0;
            alpha_r   <= '0;
            gamma_r   <= '0;
            q_r       <= '0;
            m_r       <= '0;
            delta_r   <= '0;
        end else begin
            upd_done <= 1'b0;
            upd_err  <= 1'b0;
            case (st)
                IDLE: begin
                    if (upd_valid && upd_ready) begin
                        s_r       <= state;
                        ns_r      <= next_state;
                        a_r       <= action;
                        r_r       <= reward;
                        alpha_r   <= alpha;
                        gamma_r   <= gamma;
                        upd_ready <= 1'b0;
                        st        <= FETCH;
                    end
                end
                FETCH: begin
                    q_r <= tbl[s_r][a_idx];
                    m_r <= m_w;
                    st  <= CALC;
                end
                CALC: begin
                    delta_r <= delta_w;
                    st      <= WRITE;
                end
                WRITE: begin
                    upd_done  <= 1'b1;
                    upd_err   <= !a_ok;
                    upd_ready <= 1'b1;
                    st        <= IDLE;
                end
                default: begin
                    upd_ready <= 1'b1;
                    st        <= IDLE;
                end
            endcase
        end
    end

    // Q-table storage; written only on the edge leaving WRITE with a valid action
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                for (int unsigned j = 0; j < NUM_ACTIONS; j++) begin
                    tbl[i][j] <= '0;
                end
            end
        end else if (st == WRITE && a_ok) begin
            tbl[s_r][a_idx] <= new_q;
        end
    end

    // Registered row read; samples the table before any same-edge write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q_values <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_ACTIONS; j++) begin
                rd_q_values[Q_W*j +: Q_W] <= tbl[rd_state][j];
            end
        end
    end

endmodule
